// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared UART types and constants for the receiver and transmitter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_OVERSAMPLE_DEF = 16;

    // WAIT_IDLE needs a fifth code, so the receiver state is three bits wide.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_rx_state_e;

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_START = 2'd1;
    localparam logic [1:0] c_TX_DATA  = 2'd2;
    localparam logic [1:0] c_TX_STOP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for an asynchronous single-bit input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
//------------------------------------------------------------------------------
// Module   : uart_receiver
// Brief    : 8N1 UART receiver with oversampling enable and sticky status flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
    input  logic                      clk_50m,
    input  logic                      rst_n,
    input  logic                      clken,
    input  logic                      Rx,
    input  logic                      rdy_clr,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      rdy,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      Rx_busy
);

    localparam int                  c_TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]          c_BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;

    uart_rx_state_e            r_state;
    uart_rx_state_e            w_state_nxt;
    logic [c_TICK_W-1:0]       r_tick;
    logic [c_TICK_W-1:0]       w_tick_nxt;
    logic [2:0]                r_bit_pos;
    logic [2:0]                w_bit_pos_nxt;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic [UART_DATA_BITS-1:0] w_shreg_nxt;
    logic                      w_stop_good;
    logic                      w_stop_bad;

    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_rdy;
    logic                      r_frame_err;
    logic                      r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk_50m),
        .rst_n   (rst_n),
        .i_async (Rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tick    <= '0;
            r_bit_pos <= '0;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_pos <= w_bit_pos_nxt;
            r_shreg   <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_bit_pos_nxt = r_bit_pos;
        w_shreg_nxt   = r_shreg;
        w_stop_good   = 1'b0;
        w_stop_bad    = 1'b0;

        case (r_state)
            // Leaving IDLE ignores clken so the start edge is caught at full clock resolution.
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_tick_nxt  = '0;
                end
            end

            START: begin
                if (clken) begin
                    if (w_rx_s) begin
                        w_state_nxt = IDLE;
                    end else if (r_tick == c_TICK_MID) begin
                        w_state_nxt   = DATA;
                        w_tick_nxt    = '0;
                        w_bit_pos_nxt = '0;
                    end else begin
                        w_tick_nxt = r_tick + c_TICK_W'(1);
                    end
                end
            end

            DATA: begin
                if (clken) begin
                    w_tick_nxt = r_tick + c_TICK_W'(1);
                    if (r_tick == c_TICK_LAST) begin
                        w_shreg_nxt[r_bit_pos] = w_rx_s;
                        if (r_bit_pos == c_BIT_LAST) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_pos_nxt = r_bit_pos + 3'd1;
                        end
                    end
                end
            end

            STOP: begin
                if (clken) begin
                    w_tick_nxt = r_tick + c_TICK_W'(1);
                    if (r_tick == c_TICK_LAST) begin
                        if (w_rx_s) begin
                            w_stop_good = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_stop_bad  = 1'b1;
                            w_state_nxt = WAIT_IDLE;
                        end
                    end
                end
            end

            // A held-low line (break) must not be mistaken for a new start bit.
            WAIT_IDLE: begin
                if (clken && w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A completing good byte takes priority over a same-cycle rdy_clr.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (rdy_clr) begin
                r_rdy     <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_stop_good) begin
                r_data      <= r_shreg;
                r_rdy       <= 1'b1;
                r_frame_err <= 1'b0;
                r_overrun   <= r_rdy;
            end else if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign data_out  = r_data;
    assign rdy       = r_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign Rx_busy   = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_receiver
// Brief    : Self-checking bench for uart_receiver against a frame-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_receiver;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clken   = 1'b0;
    logic       Rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] data_out;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       Rx_busy;

    uart_receiver #(
        .OVERSAMPLE (16)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .clken     (clken),
        .Rx        (Rx),
        .rdy_clr   (rdy_clr),
        .data_out  (data_out),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .Rx_busy   (Rx_busy)
    );

    always #5 clk_50m = ~clk_50m;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_div   = 1;
    int   en_cnt   = 0;
    int   cyc      = 0;
    int   t_start  = 0;
    int   t_rdy    = -1;
    logic prev_rdy = 1'b0;

    // Frame-level expectation of the receiver's visible outputs.
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy  = 1'b0;
    logic       exp_fe   = 1'b0;
    logic       exp_ovr  = 1'b0;

    always @(posedge clk_50m) cyc++;

    always @(negedge clk_50m) begin
        en_cnt = (en_cnt + 1) % en_div;
        clken  = (en_cnt == 0);
    end

    always @(negedge clk_50m) begin
        if (rdy === 1'b1 && prev_rdy !== 1'b1) t_rdy = cyc;
        prev_rdy = rdy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check($sformatf("%s.data", tag), 32'(data_out), 32'(exp_data));
        check($sformatf("%s.rdy", tag), 32'(rdy), 32'(exp_rdy));
        check($sformatf("%s.frame_err", tag), 32'(frame_err), 32'(exp_fe));
        check($sformatf("%s.overrun", tag), 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
    endtask

    // clr_at >= 0 pulses rdy_clr at that cycle of the frame; -2 holds rdy_clr
    // through the stop bit until rdy is seen, so it overlaps the completing edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
        int         bitlen;
        logic [9:0] fr;
        logic       seen;
        bitlen  = 16 * en_div;
        fr      = {stop, b, 1'b0};
        seen    = 1'b0;
        t_start = cyc;
        t_rdy   = -1;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < bitlen; c++) begin
                Rx = fr[i];
                if (clr_at == -2 && i == 9) begin
                    if (c == 0) begin
                        exp_rdy = 1'b0;
                        exp_ovr = 1'b0;
                    end
                    rdy_clr = !seen;
                end else begin
                    rdy_clr = (i * bitlen + c == clr_at);
                    if (rdy_clr) begin
                        exp_rdy = 1'b0;
                        exp_ovr = 1'b0;
                    end
                end
                @(negedge clk_50m);
                if (clr_at == -2 && i == 9 && rdy === 1'b1) seen = 1'b1;
            end
        end
        rdy_clr = 1'b0;
        if (stop) begin
            exp_ovr  = exp_rdy;
            exp_rdy  = 1'b1;
            exp_data = b;
            exp_fe   = 1'b0;
        end else begin
            exp_fe = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         busy_cnt;
        int         lat;
        logic [7:0] rb;
        logic       rs;
        int         rc;
        logic [9:0] fr;

        repeat (4) @(negedge clk_50m);
        check_outputs("reset");
        check("reset.busy", 32'(Rx_busy), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50m);

        send_frame(8'hA5, 1'b1, -1);
        check_outputs("good_a5");
        lat = t_rdy - t_start;
        check("good_a5.latency_in_range", 32'(lat >= 153 && lat <= 155), 32'd1);
        pulse_clr();
        check_outputs("clr");

        send_frame(8'h00, 1'b1, -1);
        check_outputs("b2b_clr.first");
        send_frame(8'hFF, 1'b1, 2);
        check_outputs("b2b_clr.second");
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        check_outputs("b2b_noclr");
        check("b2b_noclr.overrun_set", 32'(overrun), 32'd1);
        pulse_clr();

        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            Rx = (c < 5) ? 1'b0 : 1'b1;
            @(negedge clk_50m);
            if (Rx_busy) busy_cnt++;
        end
        check("glitch.busy_le8", 32'(busy_cnt <= 8 && busy_cnt >= 1), 32'd1);
        check("glitch.idle", 32'(Rx_busy), 32'd0);
        check_outputs("glitch");

        send_frame(8'h3C, 1'b0, -1);
        repeat (100) @(negedge clk_50m);
        check_outputs("frame_err");
        check("frame_err.wait_busy", 32'(Rx_busy), 32'd1);
        Rx = 1'b1;
        repeat (40) @(negedge clk_50m);
        check("frame_err.released", 32'(Rx_busy), 32'd0);
        send_frame(8'h3C, 1'b1, -1);
        check_outputs("frame_err.recover");

        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < ((i == 4) ? 8 : 16); c++) begin
                Rx = fr[i];
                @(negedge clk_50m);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_fe   = 1'b0;
        exp_ovr  = 1'b0;
        check_outputs("midreset");
        check("midreset.busy", 32'(Rx_busy), 32'd0);
        @(negedge clk_50m);
        Rx = 1'b1;
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_50m);
        send_frame(8'hC3, 1'b1, -1);
        check_outputs("after_reset_c3");

        en_div = 4;
        pulse_clr();
        repeat (8) @(negedge clk_50m);
        send_frame(8'h81, 1'b1, -2);
        check_outputs("sparse_81");
        repeat (8) @(negedge clk_50m);
        check("sparse_81.rdy_held", 32'(rdy), 32'd1);

        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 2))
                0:       en_div = 1;
                1:       en_div = 2;
                default: en_div = 4;
            endcase
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            rc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8 * 16 * en_div)) : -1;
            send_frame(rb, rs, rc);
            check_outputs($sformatf("rand%0d", k));
            Rx = 1'b1;
            if (!rs) begin
                repeat (3 * 16 * en_div) @(negedge clk_50m);
                check($sformatf("rand%0d.idle", k), 32'(Rx_busy), 32'd0);
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clk_50m);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: 8N1, LSB first, idle-high line. It recovers bytes from the `Rx` pin using a 16x-oversampling enable and presents each byte on a parallel port with a sticky ready flag. It is the receive-side counterpart of the design's byte transmitter and shares that transmitter's `clk_50m` domain and baud-enable generator (at 16x rate). It feeds the image-data ingest path.

## Interface
- `OVERSAMPLE`, default 16: `clken` ticks per bit period. Must be a power of two and at least 4.
- `clk_50m`, input, 1: system clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clken`, input, 1: oversample enable, one `clk_50m` cycle wide, `OVERSAMPLE` pulses per bit.
- `Rx`, input, 1: asynchronous serial line; idles high.
- `rdy_clr`, input, 1: clears `rdy` and `overrun`; level-sensitive, sampled every clock.
- `data_out`, output, 8: last good byte received; held until the next good byte.
- `rdy`, output, 1: a new byte is in `data_out`; sticky until `rdy_clr`.
- `frame_err`, output, 1: the last frame had stop bit = 0; sticky until the next good frame.
- `overrun`, output, 1: a good byte completed while `rdy` was still 1.
- `Rx_busy`, output, 1: high whenever the state is not IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized `rx_s`.
- State machine: IDLE, START, DATA, STOP, WAIT_IDLE. The 2-bit encoding is insufficient, so use 3 bits. All transitions and counter updates are qualified by `clken`, except the IDLE exit.
- Counters: tick counter `tick`, log2(`OVERSAMPLE`) bits, wraps naturally; bit index `bit_pos`, 3 bits.
- **IDLE:** on `rx_s == 0`, go to START with `tick = 0`. This check does not require `clken`.
- **START:** increment `tick` on each `clken`.
  - If `rx_s == 1` before the mid-bit point, return to IDLE (glitch reject).
  - When `tick == OVERSAMPLE/2 - 1` and `rx_s == 0`, go to DATA with `tick = 0` and `bit_pos = 0`.
- **DATA:** when `tick == OVERSAMPLE - 1`, sample at mid-bit: `shreg[bit_pos] <= rx_s`. If `bit_pos == 7`, go to STOP; otherwise increment `bit_pos`.
- **STOP:** when `tick == OVERSAMPLE - 1`, sample the stop bit.
  - If 1: `data_out <= shreg`, `rdy <= 1`, `frame_err <= 0`, `overrun <= rdy`. Go to IDLE.
  - If 0: `frame_err <= 1`; `data_out` and `rdy` are unchanged. Go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s == 1`, then go to IDLE. This absorbs break conditions and prevents a false start.
- Simultaneous `rdy_clr` and good-byte completion: the set wins, so `rdy = 1`. `overrun` takes the pre-clear value of `rdy`.
- Reset values: `data_out = 8'h00`, `rdy = 0`, `frame_err = 0`, `overrun = 0`, `Rx_busy = 0`, state IDLE, counters 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame immediately. No partial byte ever reaches `data_out`.

## Timing
- Synchronizer latency: 2 `clk_50m` cycles.
- With `clken` tied high and `OVERSAMPLE = 16`, `rdy` rises 2 + 8 + 8·16 + 16 = 154 cycles (±1) after the `Rx` start falling edge. This is the mid-point of the stop bit.
- The receiver is in IDLE from mid-stop-bit onward, so back-to-back frames are accepted with no gap.
- `rdy`, `frame_err` and `overrun` change only on the cycle of the stop-bit sample. `rdy_clr` takes effect on the next clock edge.
- `Rx_busy` is registered from state and follows it with no extra delay.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, STOP, WAIT_IDLE;
  - `UART_DATA_BITS = 8`;
  - `UART_OVERSAMPLE_DEF = 16`.
  - The transmitter's state constants move here as well.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with parameterized reset value, reusable for other async inputs.
- Everything else lives in one always block for the FSM plus a separate always block for the flags.

## Test plan
All scenarios use `clken` tied high and `OVERSAMPLE = 16` unless noted.

- **Good byte:** send 8'hA5 with 16-cycle bits → `data_out = 8'hA5`, `rdy = 1` at about 154 cycles, `frame_err = 0`, `overrun = 0`.
- **Back-to-back bytes:** send 8'h00 then 8'hFF with no gap, pulsing `rdy_clr` after the first → both bytes captured in order; `overrun = 0`. Repeat without `rdy_clr` → `overrun = 1`, `data_out = 8'hFF`.
- **Glitch reject:** 5-cycle low pulse on `Rx` → returns to IDLE; `rdy`, `frame_err` and `data_out` unchanged; `Rx_busy` high for at most 8 cycles.
- **Framing error:** send 8'h3C with stop bit = 0, then hold `Rx` low for 100 cycles → `frame_err = 1`, `rdy = 0`, FSM stays in WAIT_IDLE until `Rx` rises. A following good 8'h3C clears `frame_err`.
- **Reset mid-frame:** assert `rst_n = 0` during bit 4 of 8'h5A → all outputs return to reset values asynchronously. After release, the next full 8'hC3 is received correctly.
- **Sparse enable:** `clken` one cycle in every 4, bit period 64 cycles, send 8'h81 → `data_out = 8'h81`. Also assert `rdy_clr` on the same cycle as completion → `rdy` stays 1.
